// File: rtl/core_seq_pkg.sv
// Shared definitions for the multi-cycle sequencer: state encodings and default parameters.
// The debug and trace logic decode the same state values.
package core_seq_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5,
        ST_ERROR  = 3'd6
    } state_t;

    localparam int DEFAULT_TIMEOUT = 255;
    localparam int DEFAULT_CNT_W   = 32;

    function automatic logic is_wait_state(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/core_seq_bus_wait_timer.sv
// Counts consecutive not-ready cycles of a bus wait and flags the last allowed cycle.
// Ready on the final cycle suppresses expiry so a late response still completes normally.
module core_seq_bus_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    input  logic ready,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (inc && !ready) begin
            count <= count + CW'(1);
        end
    end

    assign expired = inc && !ready && (count == LAST);

endmodule

// File: rtl/core_seq.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with bounded bus waits and a
// retired-instruction counter. Strobes are decoded from the current state plus handshakes.
module core_seq
    import core_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
    parameter int CNT_W          = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             reg_write,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             branch,
    input  logic             branch_taken,
    input  logic             halt_req,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_we,
    output logic             alu_we,
    output logic             mdr_we,
    output logic             rf_we,
    output logic             pc_we,
    output logic             pc_sel,
    output logic             halted,
    output logic             err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    state_t           state_q;
    state_t           state_d;
    state_t           cur;
    logic [CNT_W-1:0] instret_q;
    logic             retire;
    logic             expired;
    logic             wait_ready;
    logic             timer_inc;

    logic imem_req_r, dmem_req_r, dmem_we_r, ir_we_r, alu_we_r, mdr_we_r;
    logic rf_we_r, pc_we_r, pc_sel_r, halted_r, err_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    // The unused encoding 7 behaves exactly like FETCH.
    assign cur        = (3'(state_q) == 3'd7) ? ST_FETCH : state_q;
    assign timer_inc  = is_wait_state(cur);
    assign wait_ready = (cur == ST_MEM) ? dmem_ready : imem_ready;

    core_seq_bus_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (!timer_inc),
        .inc    (timer_inc),
        .ready  (wait_ready),
        .expired(expired)
    );

    always_comb begin
        state_d    = cur;
        retire     = 1'b0;
        imem_req_r = 1'b0;
        dmem_req_r = 1'b0;
        dmem_we_r  = 1'b0;
        ir_we_r    = 1'b0;
        alu_we_r   = 1'b0;
        mdr_we_r   = 1'b0;
        rf_we_r    = 1'b0;
        pc_we_r    = 1'b0;
        pc_sel_r   = 1'b0;
        halted_r   = 1'b0;
        err_r      = 1'b0;
        case (cur)
            ST_FETCH: begin
                imem_req_r = 1'b1;
                if (imem_ready) begin
                    ir_we_r = 1'b1;
                    state_d = ST_DECODE;
                end else if (expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                alu_we_r = 1'b1;
                state_d  = (mem_read || mem_write) ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                // A request flagged as both load and store is carried out as a store.
                dmem_req_r = 1'b1;
                dmem_we_r  = mem_write;
                if (dmem_ready) begin
                    mdr_we_r = mem_read && !mem_write;
                    state_d  = ST_WB;
                end else if (expired) begin
                    state_d = ST_ERROR;
                end
            end
            ST_WB: begin
                rf_we_r  = reg_write;
                pc_we_r  = 1'b1;
                pc_sel_r = branch && branch_taken;
                retire   = 1'b1;
                state_d  = halt_req ? ST_HALT : ST_FETCH;
            end
            ST_HALT: begin
                halted_r = 1'b1;
                if (!halt_req) begin
                    state_d = ST_FETCH;
                end
            end
            ST_ERROR: err_r = 1'b1;
            default:  state_d = ST_FETCH;
        endcase
    end

    assign imem_req = imem_req_r & ~rst;
    assign dmem_req = dmem_req_r & ~rst;
    assign dmem_we  = dmem_we_r  & ~rst;
    assign ir_we    = ir_we_r    & ~rst;
    assign alu_we   = alu_we_r   & ~rst;
    assign mdr_we   = mdr_we_r   & ~rst;
    assign rf_we    = rf_we_r    & ~rst;
    assign pc_we    = pc_we_r    & ~rst;
    assign pc_sel   = pc_sel_r   & ~rst;
    assign halted   = halted_r   & ~rst;
    assign err      = err_r      & ~rst;
    assign state    = state_q;
    assign instret  = instret_q;

endmodule

// File: tb/tb_core_seq.sv
// Self-checking bench for core_seq: a per-cycle vector table of inputs and expected outputs,
// followed by hand-written sequences for the MEM timeout and back-to-back retire latency.
module tb_core_seq;

    // Input record order: rst, reg_write, mem_read, mem_write, branch, branch_taken,
    // halt_req, imem_ready, dmem_ready.
    typedef struct packed {
        logic rst;
        logic rw;
        logic mr;
        logic mw;
        logic br;
        logic bt;
        logic hr;
        logic ir;
        logic dr;
    } in_t;

    // Output record order: state, then strobes imem_req, dmem_req, dmem_we, ir_we, alu_we,
    // mdr_we, rf_we, pc_we, pc_sel, halted, err, then instret.
    typedef struct packed {
        logic [2:0]  st;
        logic [10:0] s;
        logic [31:0] cnt;
    } out_t;

    typedef struct {
        string name;
        in_t   in;
        out_t  exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, reg_write, mem_read, mem_write, branch, branch_taken;
    logic        halt_req, imem_ready, dmem_ready;
    logic        imem_req, dmem_req, dmem_we, ir_we, alu_we, mdr_we;
    logic        rf_we, pc_we, pc_sel, halted, err;
    logic [2:0]  state;
    logic [31:0] instret;

    int tests  = 0;
    int failed = 0;
    vec_t tbl[$];

    core_seq #(
        .TIMEOUT_CYCLES(4),
        .CNT_W         (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .reg_write   (reg_write),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .branch      (branch),
        .branch_taken(branch_taken),
        .halt_req    (halt_req),
        .imem_ready  (imem_ready),
        .dmem_ready  (dmem_ready),
        .imem_req    (imem_req),
        .dmem_req    (dmem_req),
        .dmem_we     (dmem_we),
        .ir_we       (ir_we),
        .alu_we      (alu_we),
        .mdr_we      (mdr_we),
        .rf_we       (rf_we),
        .pc_we       (pc_we),
        .pc_sel      (pc_sel),
        .halted      (halted),
        .err         (err),
        .state       (state),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    // Hard stop in case anything in the bench fails to make progress.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got running want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input in_t v);
        rst          = v.rst;
        reg_write    = v.rw;
        mem_read     = v.mr;
        mem_write    = v.mw;
        branch       = v.br;
        branch_taken = v.bt;
        halt_req     = v.hr;
        imem_ready   = v.ir;
        dmem_ready   = v.dr;
    endtask

    task automatic checkOutput(input string name, input out_t exp);
        out_t act;
        act = {state, imem_req, dmem_req, dmem_we, ir_we, alu_we, mdr_we,
               rf_we, pc_we, pc_sel, halted, err, instret};
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got st=%0d s=%b cnt=%0d, want st=%0d s=%b cnt=%0d",
                     name, act.st, act.s, act.cnt, exp.st, exp.s, exp.cnt);
        end
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            failed++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    function automatic void add(input string nm, input logic [8:0] i, input logic [2:0] st,
                                input logic [10:0] s, input logic [31:0] cnt);
        vec_t v;
        v.name = nm;
        v.in   = i;
        v.exp  = {st, s, cnt};
        tbl.push_back(v);
    endfunction

    // Strobe shorthands: {imem dmem dwe}_{irwe alu mdr}_{rf pcwe pcsel}_{halt err}
    localparam logic [10:0] S_NONE  = 11'b000_000_000_00;
    localparam logic [10:0] S_IMEM  = 11'b100_000_000_00;
    localparam logic [10:0] S_IRWE  = 11'b100_100_000_00;
    localparam logic [10:0] S_ALU   = 11'b000_010_000_00;
    localparam logic [10:0] S_DRD   = 11'b010_000_000_00;
    localparam logic [10:0] S_DLD   = 11'b010_001_000_00;
    localparam logic [10:0] S_DST   = 11'b011_000_000_00;
    localparam logic [10:0] S_WBRF  = 11'b000_000_110_00;
    localparam logic [10:0] S_WB    = 11'b000_000_010_00;
    localparam logic [10:0] S_WBJ   = 11'b000_000_011_00;
    localparam logic [10:0] S_HALT  = 11'b000_000_000_10;
    localparam logic [10:0] S_ERR   = 11'b000_000_000_01;

    // Input format: {rst}_{rw mr mw}_{br bt}_{hr}_{ir dr}
    initial begin
        int n;
        int mem_cycles;
        int cyc;

        applyStimulus(9'b1_000_00_0_00);
        repeat (2) @(posedge clk);

        add("rst_gated",    9'b1_000_00_0_10, 3'd0, S_NONE, 0);
        add("addi_f0",      9'b0_100_00_0_00, 3'd0, S_IMEM, 0);
        add("addi_f1",      9'b0_100_00_0_00, 3'd0, S_IMEM, 0);
        add("addi_f2",      9'b0_100_00_0_10, 3'd0, S_IRWE, 0);
        add("addi_dec",     9'b0_100_00_0_00, 3'd1, S_NONE, 0);
        add("addi_exe",     9'b0_100_00_0_00, 3'd2, S_ALU,  0);
        add("addi_wb",      9'b0_100_00_0_00, 3'd4, S_WBRF, 0);
        add("lw_f",         9'b0_110_00_0_10, 3'd0, S_IRWE, 1);
        add("lw_dec",       9'b0_110_00_0_00, 3'd1, S_NONE, 1);
        add("lw_exe",       9'b0_110_00_0_00, 3'd2, S_ALU,  1);
        add("lw_mem0",      9'b0_110_00_0_00, 3'd3, S_DRD,  1);
        add("lw_mem1",      9'b0_110_00_0_00, 3'd3, S_DRD,  1);
        add("lw_mem2",      9'b0_110_00_0_00, 3'd3, S_DRD,  1);
        add("lw_mem3",      9'b0_110_00_0_01, 3'd3, S_DLD,  1);
        add("lw_wb",        9'b0_110_00_0_00, 3'd4, S_WBRF, 1);
        add("sw_f",         9'b0_001_00_0_10, 3'd0, S_IRWE, 2);
        add("sw_dec",       9'b0_001_00_0_00, 3'd1, S_NONE, 2);
        add("sw_exe",       9'b0_001_00_0_00, 3'd2, S_ALU,  2);
        add("sw_mem",       9'b0_001_00_0_01, 3'd3, S_DST,  2);
        add("sw_wb",        9'b0_001_00_0_00, 3'd4, S_WB,   2);
        add("bt_f",         9'b0_000_11_0_10, 3'd0, S_IRWE, 3);
        add("bt_dec",       9'b0_000_11_0_00, 3'd1, S_NONE, 3);
        add("bt_exe",       9'b0_000_11_0_00, 3'd2, S_ALU,  3);
        add("bt_wb",        9'b0_000_11_0_00, 3'd4, S_WBJ,  3);
        add("bnt_f",        9'b0_000_10_0_10, 3'd0, S_IRWE, 4);
        add("bnt_dec",      9'b0_000_10_0_00, 3'd1, S_NONE, 4);
        add("bnt_exe",      9'b0_000_10_0_00, 3'd2, S_ALU,  4);
        add("bnt_wb",       9'b0_000_10_0_00, 3'd4, S_WB,   4);
        add("ill_f",        9'b0_111_00_0_10, 3'd0, S_IRWE, 5);
        add("ill_dec",      9'b0_111_00_0_00, 3'd1, S_NONE, 5);
        add("ill_exe",      9'b0_111_00_0_00, 3'd2, S_ALU,  5);
        add("ill_mem",      9'b0_111_00_0_01, 3'd3, S_DST,  5);
        add("ill_wb",       9'b0_111_00_0_00, 3'd4, S_WBRF, 5);
        add("halt_f",       9'b0_000_00_1_10, 3'd0, S_IRWE, 6);
        add("halt_dec",     9'b0_000_00_1_00, 3'd1, S_NONE, 6);
        add("halt_exe",     9'b0_000_00_1_00, 3'd2, S_ALU,  6);
        add("halt_wb",      9'b0_000_00_1_00, 3'd4, S_WB,   6);
        add("halt_hold",    9'b0_000_00_1_00, 3'd5, S_HALT, 7);
        add("halt_drop",    9'b0_000_00_0_00, 3'd5, S_HALT, 7);
        add("halt_exit",    9'b0_000_00_0_00, 3'd0, S_IMEM, 7);
        add("rmem_f",       9'b0_110_00_0_10, 3'd0, S_IRWE, 7);
        add("rmem_dec",     9'b0_110_00_0_00, 3'd1, S_NONE, 7);
        add("rmem_exe",     9'b0_110_00_0_00, 3'd2, S_ALU,  7);
        add("rmem_mem",     9'b0_110_00_0_00, 3'd3, S_DRD,  7);
        add("rmem_rst",     9'b1_110_00_0_00, 3'd3, S_NONE, 7);
        add("to_f0",        9'b0_000_00_0_00, 3'd0, S_IMEM, 0);
        add("to_f1",        9'b0_000_00_0_00, 3'd0, S_IMEM, 0);
        add("to_f2",        9'b0_000_00_0_00, 3'd0, S_IMEM, 0);
        add("to_f3",        9'b0_000_00_0_00, 3'd0, S_IMEM, 0);
        add("to_err0",      9'b0_000_00_0_10, 3'd6, S_ERR,  0);
        add("to_err1",      9'b0_000_00_0_00, 3'd6, S_ERR,  0);
        add("to_err_rst",   9'b1_000_00_0_00, 3'd6, S_NONE, 0);
        add("late_f0",      9'b0_000_00_0_00, 3'd0, S_IMEM, 0);
        add("late_f1",      9'b0_000_00_0_00, 3'd0, S_IMEM, 0);
        add("late_f2",      9'b0_000_00_0_00, 3'd0, S_IMEM, 0);
        add("late_f3",      9'b0_000_00_0_10, 3'd0, S_IRWE, 0);
        add("late_dec",     9'b0_000_00_0_00, 3'd1, S_NONE, 0);
        add("late_exe",     9'b0_000_00_0_00, 3'd2, S_ALU,  0);
        add("late_wb",      9'b0_000_00_0_00, 3'd4, S_WB,   0);
        add("late_next",    9'b0_000_00_0_00, 3'd0, S_IMEM, 1);

        // Each table row is one clock: drive on the falling edge, sample just after.
        foreach (tbl[k]) begin
            @(negedge clk);
            applyStimulus(tbl[k].in);
            #1;
            checkOutput(tbl[k].name, tbl[k].exp);
        end

        // A load whose data port never answers must spend exactly four cycles in MEM.
        @(negedge clk);
        applyStimulus(9'b1_000_00_0_00);
        @(negedge clk);
        applyStimulus(9'b0_110_00_0_10);
        n = 0;
        #1;
        while (state != 3'd3 && n < 10) begin
            @(negedge clk);
            n++;
            #1;
        end
        checkVal("mto_reach_mem", int'(state), 3);
        mem_cycles = 0;
        while (state == 3'd3 && mem_cycles < 20) begin
            mem_cycles++;
            @(negedge clk);
            #1;
        end
        checkVal("mto_mem_len", mem_cycles, 4);
        checkVal("mto_state", int'(state), 6);
        checkVal("mto_err", int'(err), 1);
        checkVal("mto_dmem_req", int'(dmem_req), 0);
        checkVal("mto_instret", int'(instret), 0);

        // Five zero-wait ALU instructions back to back retire in twenty cycles.
        @(negedge clk);
        applyStimulus(9'b1_000_00_0_00);
        @(negedge clk);
        applyStimulus(9'b0_100_00_0_10);
        #1;
        checkVal("b2b_start", int'(instret), 0);
        cyc = 0;
        while (instret < 5 && cyc < 100) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        checkVal("b2b_instret", int'(instret), 5);
        checkVal("b2b_cycles", cyc, 20);

        @(negedge clk);
        applyStimulus(9'b1_000_00_0_00);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
